// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers recorder samples and emits fixed-length AXI-stream FFT frames.
// Build option FEEDER_PAD_EN: zero-pad flushed partial frames to FRAME_LEN instead of cutting them short.
module fft_frame_feeder #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_LEN    = 2048,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    audio_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  input  logic                    flush_in,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [15:0]             frame_count_out,
  output logic [15:0]             overflow_count_out,
  output logic                    busy_out
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE      = (AW + 1)'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

`ifdef FEEDER_PAD_EN
  typedef enum logic [1:0] {STREAM, FLUSH, PAD} state_t;
`else
  typedef enum logic [1:0] {STREAM, FLUSH} state_t;
`endif

  state_t state, state_nxt;

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [IW-1:0] index, index_nxt;
  logic [HW-1:0] re;
  logic empty, xfer, pop, wr_req, push, drop;

  // Beat presentation: FIFO head in STREAM/FLUSH, forced zero beats when padding.
  always_comb begin
    empty = (count == '0);
    re = HW'(mem[rd_ptr]) << (HW - SAMPLE_WIDTH);
    m_axis_tdata = empty ? '0 : {{(DATA_WIDTH - HW){1'b0}}, re};
    m_axis_tvalid = !empty;
    m_axis_tlast = !empty && (index == LAST_IDX);
`ifdef FEEDER_PAD_EN
    if (state == PAD) begin
      m_axis_tvalid = 1'b1;
      m_axis_tlast = (index == LAST_IDX);
    end
`else
    // An empty FIFO here still owes one zero beat to close the frame.
    if (state == FLUSH) begin
      m_axis_tvalid = 1'b1;
      m_axis_tlast = (count <= ONE) || (index == LAST_IDX);
    end
`endif
  end

  // Handshake, FIFO bookkeeping and post-transfer beat index.
  always_comb begin
    xfer = m_axis_tvalid && m_axis_tready;
    pop = xfer && !empty;
    wr_req = audio_valid_in && enable_in && (state == STREAM);
    push = wr_req && ((count != FULL) || pop);
    drop = wr_req && (count == FULL) && !pop;
    count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);
    index_nxt = index;
    if (xfer) index_nxt = m_axis_tlast ? '0 : index + 1'b1;
  end

  // Next state; a flush is judged against the state after this cycle's transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      STREAM:
        if (flush_in && ((index_nxt != '0) || (count_nxt != '0)))
          state_nxt = FLUSH;
`ifdef FEEDER_PAD_EN
      FLUSH:
        if (empty) state_nxt = (index == '0) ? STREAM : PAD;
      PAD:
        if (xfer && m_axis_tlast) state_nxt = STREAM;
`else
      FLUSH:
        if (xfer && m_axis_tlast && (count_nxt == '0)) state_nxt = STREAM;
`endif
      default: state_nxt = STREAM;
    endcase
  end

  // Control registers and counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= STREAM;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      index <= '0;
      frame_count_out <= '0;
      overflow_count_out <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      index <= index_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (xfer && m_axis_tlast) frame_count_out <= frame_count_out + 16'd1;
      if (drop && (overflow_count_out != 16'hFFFF))
        overflow_count_out <= overflow_count_out + 16'd1;
    end
  end

  // Sample storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= audio_in;
  end

  assign busy_out = (state != STREAM);

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed plus random stimulus against a queue-based stream model.
// Expectations for flushed frames follow the FEEDER_PAD_EN build option.
module tb_fft_frame_feeder;

  localparam int FL = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic av = 1'b0;
  logic flush = 1'b0;
  logic tready = 1'b0;
  logic [7:0] audio = '0;
  logic [31:0] tdata;
  logic tvalid, tlast, busy;
  logic [15:0] fcnt, ocnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  int mbeat, mframes, movf;
  bit model_on = 1'b0;
  logic [31:0] od[$];
  logic ol[$];
  logic [31:0] ed[$];
  logic el[$];
  logic busy_s;

  always #5 clk = ~clk;

  fft_frame_feeder #(
    .SAMPLE_WIDTH(8),
    .DATA_WIDTH(32),
    .FRAME_LEN(FL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .enable_in(en),
    .audio_valid_in(av),
    .audio_in(audio),
    .flush_in(flush),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
    .frame_count_out(fcnt),
    .overflow_count_out(ocnt),
    .busy_out(busy)
  );

  function automatic logic [31:0] pack(input logic [7:0] s);
    return {16'h0000, s, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mbeat = 0;
    mframes = 0;
    movf = 0;
  endtask

  task automatic tick();
    bit pop;
    @(negedge clk);
    busy_s = busy;
    if (model_on) begin
      chk("tvalid", 32'(tvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("tdata", tdata, pack(mq[0]));
        chk("tlast", 32'(tlast), 32'(mbeat == FL - 1));
      end
    end
    if (tvalid && tready) begin
      od.push_back(tdata);
      ol.push_back(tlast);
    end
    if (model_on) begin
      pop = (mq.size() != 0) && tready;
      if (pop) begin
        void'(mq.pop_front());
        if (mbeat == FL - 1) begin
          mbeat = 0;
          mframes++;
        end else begin
          mbeat++;
        end
      end
      if (av && en) begin
        if (mq.size() < DEPTH) mq.push_back(audio);
        else if (movf < 65535) movf++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [7:0] s);
    av = 1'b1;
    audio = s;
    tick();
    av = 1'b0;
  endtask

  task automatic clear_obs();
    od.delete();
    ol.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    mreset();
  endtask

  task automatic collect();
    int n;
    n = 0;
    while ((ol.size() == 0 || ol[ol.size() - 1] !== 1'b1) && n < 40) begin
      tick();
      n++;
      chk("busy_during_flush", 32'(busy_s), 32'd1);
    end
    chk("flush_done_in_budget", 32'(n < 40), 32'd1);
    tick();
    chk("busy_after_flush", 32'(busy_s), 32'd0);
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_beats"}, 32'(od.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size(); i++) begin
      if (i < od.size()) begin
        chk({tag, "_data"}, od[i], ed[i]);
        chk({tag, "_last"}, 32'(ol[i]), 32'(el[i]));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({tag, "_tdata"}, tdata, 32'd0);
    chk({tag, "_tlast"}, 32'(tlast), 32'd0);
    chk({tag, "_frames"}, 32'(fcnt), 32'd0);
    chk({tag, "_overflow"}, 32'(ocnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    mreset();
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // full frames, no backpressure
    model_on = 1'b1;
    en = 1'b1;
    tready = 1'b1;
    clear_obs();
    for (int i = 0; i < 16; i++) strobe(8'(i));
    idle(3);
    chk("t1_beats", 32'(od.size()), 32'd16);
    chk("t1_frames", 32'(fcnt), 32'd2);
    chk("t1_frames_model", 32'(fcnt), 32'(mframes));
    chk("t1_overflow", 32'(ocnt), 32'd0);

    // backpressure and overflow
    tready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(8'(i));
    idle(2);
    chk("t2_overflow", 32'(ocnt), 32'd2);
    chk("t2_overflow_model", 32'(ocnt), 32'(movf));
    clear_obs();
    tready = 1'b1;
    idle(6);
    chk("t2_beats", 32'(od.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < od.size()) chk("t2_sample", od[i], pack(8'(i)));

    // asynchronous reset mid-frame: index 5, two queued samples
    strobe(8'h11);
    idle(1);
    tready = 1'b0;
    strobe(8'h22);
    strobe(8'h33);
    idle(1);
    chk("t5_pre_tvalid", 32'(tvalid), 32'd1);
    model_on = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    mreset();
    model_on = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 8; i++) strobe(8'($urandom));
    idle(3);
    chk("t5_frames", 32'(fcnt), 32'd1);

    // writes blocked while disabled; ignored flush
    en = 1'b0;
    clear_obs();
    for (int i = 0; i < 10; i++) strobe(8'(i + 1));
    idle(2);
    chk("t6_beats", 32'(od.size()), 32'd0);
    chk("t6_overflow", 32'(ocnt), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_busy_now", 32'(busy), 32'd0);
    idle(2);
    chk("t6_busy_later", 32'(busy_s), 32'd0);
    chk("t6_tvalid", 32'(tvalid), 32'd0);
    en = 1'b1;

    // random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      av = 1'($urandom);
      en = ($urandom % 4) != 0;
      tready = ($urandom % 3) != 0;
      audio = 8'($urandom);
      tick();
    end
    av = 1'b0;
    en = 1'b1;
    tready = 1'b1;
    idle(DEPTH + 2);
    chk("rand_frames", 32'(fcnt), 32'(mframes));
    chk("rand_overflow", 32'(ocnt), 32'(movf));

    // flush of a partial frame held in the FIFO
    model_on = 1'b0;
    pulse_reset();
    tready = 1'b0;
    clear_obs();
    for (int i = 0; i < 3; i++) strobe(8'hA0 + 8'(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tready = 1'b1;
    collect();
    ed.delete();
    el.delete();
`ifdef FEEDER_PAD_EN
    for (int i = 0; i < FL; i++) begin
      ed.push_back(i < 3 ? pack(8'hA0 + 8'(i)) : 32'd0);
      el.push_back(i == FL - 1);
    end
`else
    for (int i = 0; i < 3; i++) begin
      ed.push_back(pack(8'hA0 + 8'(i)));
      el.push_back(i == 2);
    end
`endif
    cmp_beats("flush_fifo");
    chk("flush_fifo_frames", 32'(fcnt), 32'd1);

    // following frame starts at index 0
    mreset();
    mframes = 1;
    model_on = 1'b1;
    for (int i = 0; i < 8; i++) strobe(8'($urandom));
    idle(3);
    chk("after_flush_frames", 32'(fcnt), 32'd2);

    // flush with empty FIFO at index 2
    strobe(8'h5A);
    strobe(8'h5B);
    idle(2);
    model_on = 1'b0;
    clear_obs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect();
    ed.delete();
    el.delete();
`ifdef FEEDER_PAD_EN
    for (int i = 2; i < FL; i++) begin
      ed.push_back(32'd0);
      el.push_back(i == FL - 1);
    end
`else
    ed.push_back(32'd0);
    el.push_back(1'b1);
`endif
    cmp_beats("flush_empty");
    chk("flush_empty_frames", 32'(fcnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
